// File: rtl/branch_rs.sv
// rtl/branch_rs.sv - compacting reservation station feeding the branch unit.
// Optional empty-queue dispatch-to-issue bypass enabled by defining BRS_BYPASS_EN.
module branch_rs #(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = 5,
  parameter int XLEN    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [5:0]       dispatch_func,
  input  logic [XLEN-1:0]  dispatch_pc,
  input  logic [XLEN-1:0]  dispatch_imm,
  input  logic [TAG_W-1:0] dispatch_rob_tag,
  input  logic             dispatch_rs1_ready,
  input  logic [XLEN-1:0]  dispatch_rs1_value,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic             dispatch_rs2_ready,
  input  logic [XLEN-1:0]  dispatch_rs2_value,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             fu_ready,
  output logic             full,
  output logic             issue_valid,
  output logic [5:0]       issue_func,
  output logic [XLEN-1:0]  issue_pc,
  output logic [XLEN-1:0]  issue_imm,
  output logic [XLEN-1:0]  issue_rs1,
  output logic [XLEN-1:0]  issue_rs2,
  output logic [TAG_W-1:0] issue_rob_tag
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [5:0]       func;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] rob_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [XLEN-1:0]  rs2_val;
    logic [TAG_W-1:0] rs2_tag;
  } entry_t;

  entry_t          r_q [RS_SIZE];
  logic [CW-1:0]   r_count;

  entry_t          w_wake  [RS_SIZE];
  entry_t          w_shift [RS_SIZE];
  entry_t          w_new;
  entry_t          w_out;
  logic            w_found;
  logic [IW-1:0]   w_sel;
  logic            w_full;
  logic            w_fire;
  logic            w_bypass;
  logic            w_accept;
  logic [IW-1:0]   w_wr_idx;

  // Incoming op with same-cycle CDB forwarding applied.
  always_comb begin
    w_new.func    = dispatch_func;
    w_new.pc      = dispatch_pc;
    w_new.imm     = dispatch_imm;
    w_new.rob_tag = dispatch_rob_tag;
    w_new.rs1_tag = dispatch_rs1_tag;
    w_new.rs2_tag = dispatch_rs2_tag;
    w_new.rs1_rdy = dispatch_rs1_ready;
    w_new.rs1_val = dispatch_rs1_value;
    w_new.rs2_rdy = dispatch_rs2_ready;
    w_new.rs2_val = dispatch_rs2_value;
    if (!dispatch_rs1_ready && cdb_valid && (cdb_tag == dispatch_rs1_tag)) begin
      w_new.rs1_rdy = 1'b1;
      w_new.rs1_val = cdb_value;
    end
    if (!dispatch_rs2_ready && cdb_valid && (cdb_tag == dispatch_rs2_tag)) begin
      w_new.rs2_rdy = 1'b1;
      w_new.rs2_val = cdb_value;
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wake[i] = r_q[i];
      if (cdb_valid && !r_q[i].rs1_rdy && (r_q[i].rs1_tag == cdb_tag)) begin
        w_wake[i].rs1_rdy = 1'b1;
        w_wake[i].rs1_val = cdb_value;
      end
      if (cdb_valid && !r_q[i].rs2_rdy && (r_q[i].rs2_tag == cdb_tag)) begin
        w_wake[i].rs2_rdy = 1'b1;
        w_wake[i].rs2_val = cdb_value;
      end
    end
  end

  // Selection looks only at stored state, never at this cycle's CDB.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if ((CW'(i) < r_count) && r_q[i].rs1_rdy && r_q[i].rs2_rdy) begin
        w_found = 1'b1;
        w_sel   = IW'(i);
      end
    end
  end

  assign w_full = (r_count == CW'(RS_SIZE));
  assign w_fire = w_found && fu_ready;

`ifdef BRS_BYPASS_EN
  assign w_bypass = (r_count == '0) && dispatch_valid && w_new.rs1_rdy && w_new.rs2_rdy &&
                    fu_ready && !flush && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_accept = dispatch_valid && !w_full && !w_bypass;
  assign w_wr_idx = IW'(r_count - CW'(w_fire));

  always_comb begin
    for (int i = 0; i < RS_SIZE - 1; i++) begin
      if (w_fire && (IW'(i) >= w_sel)) w_shift[i] = w_wake[i+1];
      else                            w_shift[i] = w_wake[i];
    end
    w_shift[RS_SIZE-1] = w_wake[RS_SIZE-1];
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_count <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_q[i].rs1_rdy <= 1'b0;
        r_q[i].rs2_rdy <= 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) r_q[i] <= w_shift[i];
      if (w_accept) r_q[w_wr_idx] <= w_new;
      r_count <= r_count - CW'(w_fire) + CW'(w_accept);
    end
  end

  always_comb begin
    w_out = '0;
    if (w_bypass)     w_out = w_new;
    else if (w_found) w_out = r_q[w_sel];
  end

  assign full          = w_full;
  assign issue_valid   = w_bypass || w_found;
  assign issue_func    = w_out.func;
  assign issue_pc      = w_out.pc;
  assign issue_imm     = w_out.imm;
  assign issue_rs1     = w_out.rs1_val;
  assign issue_rs2     = w_out.rs2_val;
  assign issue_rob_tag = w_out.rob_tag;

endmodule

// File: tb/tb_branch_rs.sv
// tb/tb_branch_rs.sv - randomized and directed bench for branch_rs against a queue-level model.
module tb_branch_rs;
  localparam int RS = 4;
  localparam int TW = 5;
  localparam int XL = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, flush, dv, d1r, d2r, cv, fu;
  logic [5:0]    dfunc;
  logic [XL-1:0] dpc, dimm, d1v, d2v, cval;
  logic [TW-1:0] dtag, d1t, d2t, ct;

  logic          full, issue_valid;
  logic [5:0]    issue_func;
  logic [XL-1:0] issue_pc, issue_imm, issue_rs1, issue_rs2;
  logic [TW-1:0] issue_rob_tag;

  branch_rs #(.RS_SIZE(RS), .TAG_W(TW), .XLEN(XL)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .dispatch_valid(dv), .dispatch_func(dfunc), .dispatch_pc(dpc), .dispatch_imm(dimm),
    .dispatch_rob_tag(dtag),
    .dispatch_rs1_ready(d1r), .dispatch_rs1_value(d1v), .dispatch_rs1_tag(d1t),
    .dispatch_rs2_ready(d2r), .dispatch_rs2_value(d2v), .dispatch_rs2_tag(d2t),
    .cdb_valid(cv), .cdb_tag(ct), .cdb_value(cval), .fu_ready(fu),
    .full(full), .issue_valid(issue_valid), .issue_func(issue_func), .issue_pc(issue_pc),
    .issue_imm(issue_imm), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rob_tag(issue_rob_tag)
  );

  typedef struct {
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rob;
    bit          r1;
    logic [31:0] v1;
    logic [4:0]  t1;
    bit          r2;
    logic [31:0] v2;
    logic [4:0]  t2;
  } op_t;

  op_t mq[$];
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic op_t incoming();
    op_t o;
    o.func = dfunc; o.pc = dpc; o.imm = dimm; o.rob = dtag;
    o.t1 = d1t; o.t2 = d2t;
    o.r1 = d1r || (cv && ct == d1t);
    o.v1 = d1r ? d1v : cval;
    o.r2 = d2r || (cv && ct == d2t);
    o.v2 = d2r ? d2v : cval;
    return o;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  function automatic bit bypass_now();
`ifdef BRS_BYPASS_EN
    op_t o;
    o = incoming();
    return (mq.size() == 0) && dv && o.r1 && o.r2 && fu && !flush && !reset;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [139:0] expected();
    op_t o;
    int  s;
    if (bypass_now()) o = incoming();
    else begin
      s = oldest_ready();
      if (s < 0) return '0;
      o = mq[s];
    end
    return {1'b1, o.func, o.pc, o.imm, o.v1, o.v2, o.rob};
  endfunction

  task automatic model_step();
    bit  byp;
    bit  was_full;
    int  s;
    op_t t;
    if (reset || flush) begin
      mq.delete();
    end else begin
      byp      = bypass_now();
      s        = oldest_ready();
      was_full = (mq.size() == RS);
      if (s >= 0 && fu) mq.delete(s);
      foreach (mq[i]) begin
        t = mq[i];
        if (cv && !t.r1 && t.t1 == ct) begin t.r1 = 1'b1; t.v1 = cval; end
        if (cv && !t.r2 && t.t2 == ct) begin t.r2 = 1'b1; t.v2 = cval; end
        mq[i] = t;
      end
      if (dv && !was_full && !byp) mq.push_back(incoming());
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("issue", {issue_valid, issue_func, issue_pc, issue_imm, issue_rs1, issue_rs2, issue_rob_tag},
          expected());
      chk("full", full, mq.size() == RS);
    end
  end

  task automatic idle();
    dv = 0; cv = 0; flush = 0;
    dfunc = '0; dpc = '0; dimm = '0; dtag = '0;
    d1r = 0; d1v = '0; d1t = '0; d2r = 0; d2v = '0; d2t = '0;
    ct = '0; cval = '0;
  endtask

  task automatic adv();
    @(posedge clock);
    model_step();
    #1;
    idle();
  endtask

  task automatic neg();
    @(negedge clock);
    #1;
  endtask

  task automatic disp(input logic [5:0] f, input logic [31:0] pc, input logic [31:0] imm,
                      input logic [4:0] tag, input logic r1, input logic [31:0] v1,
                      input logic [4:0] t1, input logic r2, input logic [31:0] v2,
                      input logic [4:0] t2);
    dv = 1; dfunc = f; dpc = pc; dimm = imm; dtag = tag;
    d1r = r1; d1v = v1; d1t = t1; d2r = r2; d2v = v2; d2t = t2;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val);
    cv = 1; ct = tag; cval = val;
  endtask

  initial begin
    idle();
    fu = 0; reset = 1;
    adv(); adv();
    reset = 0;
    neg(); chk("reset_valid", issue_valid, 1'b0); chk("reset_full", full, 1'b0); adv();

    fu = 1;
    disp(6'h0e, 32'h100, 32'h20, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd5, 5'd0);
    neg();
`ifdef BRS_BYPASS_EN
    chk("t1_valid", issue_valid, 1'b1); chk("t1_pc", issue_pc, 32'h100);
    chk("t1_tag", issue_rob_tag, 5'd3); adv();
    neg(); chk("t1_empty", issue_valid, 1'b0); adv();
`else
    chk("t1_wait", issue_valid, 1'b0); adv();
    neg(); chk("t1_valid", issue_valid, 1'b1); chk("t1_pc", issue_pc, 32'h100);
    chk("t1_tag", issue_rob_tag, 5'd3); adv();
    neg(); chk("t1_empty", issue_valid, 1'b0); chk("t1_full", full, 1'b0); adv();
`endif

    disp(6'h10, 32'h200, 32'h8, 5'd4, 1'b0, 32'd0, 5'd7, 1'b1, 32'h55, 5'd0);
    neg(); chk("t2_wait0", issue_valid, 1'b0); adv();
    cdb(5'd7, 32'hFFFF_FFFF);
    neg(); chk("t2_wait1", issue_valid, 1'b0); adv();
    neg(); chk("t2_valid", issue_valid, 1'b1); chk("t2_rs1", issue_rs1, 32'hFFFF_FFFF);
    chk("t2_tag", issue_rob_tag, 5'd4); adv();

    fu = 0;
    for (int k = 0; k < 4; k++) begin
      disp(6'(14 + k), 32'h300 + 32'(4 * k), 32'(k), 5'(10 + k), 1'b1, 32'(k), 5'd0,
           1'b1, 32'(k + 1), 5'd0);
      neg(); adv();
    end
    disp(6'h0e, 32'h3f0, 32'd0, 5'd14, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    neg(); chk("t3_full", full, 1'b1); adv();
    fu = 1;
    neg(); chk("t3_slot0", issue_rob_tag, 5'd10); adv();
    fu = 0;
    neg(); chk("t3_notfull", full, 1'b0); chk("t3_shift", issue_rob_tag, 5'd11); adv();
    fu = 1;
    neg(); chk("t3_d11", issue_rob_tag, 5'd11); adv();
    neg(); chk("t3_d12", issue_rob_tag, 5'd12); adv();
    neg(); chk("t3_d13", issue_rob_tag, 5'd13); adv();
    neg(); chk("t3_dropped", issue_valid, 1'b0); adv();

    fu = 0;
    disp(6'h0f, 32'h400, 32'd0, 5'd20, 1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0);
    neg(); adv();
    disp(6'h11, 32'h404, 32'd0, 5'd21, 1'b1, 32'd2, 5'd0, 1'b1, 32'd3, 5'd0);
    neg(); adv();
    fu = 1;
    neg(); chk("t4_young", issue_rob_tag, 5'd21); adv();
    cdb(5'd9, 32'h1234);
    neg(); chk("t4_wait", issue_valid, 1'b0); adv();
    neg(); chk("t4_old", issue_rob_tag, 5'd20); chk("t4_rs1", issue_rs1, 32'h1234); adv();

    fu = 0;
    for (int k = 0; k < 3; k++) begin
      disp(6'h12, 32'h600, 32'd0, 5'(24 + k), 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
      neg(); adv();
    end
    flush = 1;
    disp(6'h12, 32'h610, 32'd0, 5'd27, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    neg(); adv();
    neg(); chk("t5_valid", issue_valid, 1'b0); chk("t5_full", full, 1'b0); adv();
    disp(6'h13, 32'h620, 32'd0, 5'd28, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    neg(); adv();
    fu = 1;
    neg(); chk("t5_fresh", issue_rob_tag, 5'd28); adv();

    disp(6'h14, 32'h500, 32'h40, 5'd30, 1'b1, 32'd0, 5'd0, 1'b1, 32'd0, 5'd0);
    neg();
`ifdef BRS_BYPASS_EN
    chk("t6_same", issue_valid, 1'b1); chk("t6_tag", issue_rob_tag, 5'd30); adv();
    neg(); chk("t6_notq", issue_valid, 1'b0); adv();
`else
    chk("t6_same", issue_valid, 1'b0); adv();
    neg(); chk("t6_next", issue_valid, 1'b1); chk("t6_tag", issue_rob_tag, 5'd30); adv();
`endif

    for (int c = 0; c < 3000; c++) begin
      dv    = ($urandom_range(0, 9) < 6);
      dfunc = 6'(14 + $urandom_range(0, 7));
      dpc   = $urandom; dimm = $urandom; dtag = 5'($urandom_range(0, 31));
      d1r   = 1'($urandom_range(0, 1)); d1v = $urandom; d1t = 5'($urandom_range(0, 7));
      d2r   = 1'($urandom_range(0, 1)); d2v = $urandom; d2t = 5'($urandom_range(0, 7));
      if (dfunc == 6'h14) begin d1r = 1; d2r = 1; end
      if (dfunc == 6'h15) d2r = 1;
      cv    = ($urandom_range(0, 1) == 1);
      ct    = 5'($urandom_range(0, 7)); cval = $urandom;
      fu    = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      neg(); adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
